ps2_kbd_ctrl: RTL and testbench
===============================

PS2_KBD_CTRL -- requirements
Module: ps2_kbd_ctrl

Interface
REQ-001 Param CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Param TIMEOUT_US, default 2000, max gap between bytes of one multi-byte scan sequence.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 reset  in  1  reset, synchronous, active-low.
REQ-005 rx_done  in  1  one-cycle strobe: rx_data holds a new byte from the PS/2 receiver.
REQ-006 rx_data  in  8  received byte, valid only while rx_done=1.
REQ-007 ev_valid  out  1  event FIFO non-empty.
REQ-008 ev_ready  in  1  consumer pops the head event when ev_valid and ev_ready are both 1.
REQ-009 ev_code  out  8  head event scan code.
REQ-010 ev_ext  out  1  head event is an E0-extended key.
REQ-011 ev_rel  out  1  head event is a release (break), not a make.
REQ-012 ev_pause  out  1  head event is the Pause key (ev_code=8'hE1, ev_ext=0, ev_rel=0).
REQ-013 sts_valid  out  1  one-cycle strobe: a keyboard status byte was received.
REQ-014 sts_code  out  8  status byte, valid while sts_valid=1.
REQ-015 to_err  out  1  one-cycle strobe: sequence timeout.
REQ-016 ovf  out  1  sticky: an event was dropped because the FIFO was full.
REQ-017 ovf_clr  in  1  clears ovf.

Function
REQ-018 The FSM SHALL have states IDLE, EXT, BRK and PAUSE, plus an ext_flag register, and SHALL advance only on cycles with rx_done=1, except for timeout.
REQ-019 IDLE: E0 -> EXT; F0 -> BRK with ext_flag=0; E1 -> PAUSE with skip_cnt=7; AA/FA/EE/FE/FC/00/FF -> stay IDLE and pulse sts_valid; any other byte -> push make {code, ext=0}.
REQ-020 EXT: F0 -> BRK with ext_flag=1; E0 -> stay EXT; 12 or 59 (fake shift) -> IDLE with no push; other -> push make {code, ext=1}, then IDLE.
REQ-021 BRK: any byte -> push release {code, ext=ext_flag}, then IDLE; if ext_flag=1 and the byte is 12 or 59, discard with no push.
REQ-022 PAUSE: decrement skip_cnt on each byte; on the byte where skip_cnt=1, push a pause event and return to IDLE; byte contents are ignored.
REQ-023 sts_valid/sts_code SHALL assert in the cycle after the rx_done cycle.
REQ-024 Latency: an event pushed on rx_done in cycle N SHALL be visible on ev_* in cycle N+1 if the FIFO was empty.
REQ-025 Timeout counter: cleared on every rx_done and held at 0 in IDLE; at TIMEOUT_US*(CLK_HZ/1_000_000) cycles in EXT/BRK/PAUSE -> IDLE, ext_flag=0, to_err pulses 1 cycle, no push.
REQ-026 rx_done in the same cycle as the timeout terminal count: the byte wins and the timeout is ignored.
REQ-027 FIFO: 4 entries, 11 bits {pause, ext, rel, code}, first-word fall-through, ev_* driven from the head.
REQ-028 Push when full without a same-cycle pop: the event is dropped and ovf is set; FIFO contents are unchanged.
REQ-029 Push and pop in the same cycle when full: both take effect, count stays 4, ovf unchanged.
REQ-030 Push and pop in the same cycle when empty: no bypass; the event appears next cycle.
REQ-031 Pop when empty SHALL be ignored.
REQ-032 ovf_clr and a new overflow in the same cycle: ovf stays 1 (set wins).
REQ-033 Count and pointer widths SHALL wrap modulo depth; count SHALL never exceed 4.

Reset
REQ-034 With reset=0 at a clk edge: FSM=IDLE, ext_flag=0, skip_cnt=0, timeout counter=0, FIFO empty, ev_valid=0, sts_valid=0, to_err=0, ovf=0.
REQ-035 Reset mid-sequence (e.g. in BRK) SHALL abandon the sequence with no event; the first byte after reset is decoded from IDLE.
REQ-036 ev_code/ev_ext/ev_rel/ev_pause SHALL be 0 while the FIFO is empty after reset.

Structure
REQ-037 Shared package ps2_pkg SHALL hold the byte constants (E0, F0, E1, status bytes, fake-shift codes), FSM state encodings, the event record width (11) and field offsets.
REQ-038 The FIFO SHALL be a sub-module ps2_evt_fifo (params WIDTH, DEPTH) containing storage, pointers, count and full/empty logic.
REQ-039 The decoder FSM, timeout counter and status/ovf flags SHALL reside in ps2_kbd_ctrl.

Verification
REQ-040 Bytes 1C; F0 1C, with ev_ready=1 -> events {1C, make}, then {1C, rel, ext=0}, each one cycle after its rx_done.
REQ-041 Bytes E0 75; E0 F0 75; E0 12 -> {75, ext} make, then {75, ext, rel}; no event for the fake shift.
REQ-042 Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one event with ev_pause=1 and ev_code=E1.
REQ-043 ev_ready=0, six make bytes -> four events held, ovf=1; ovf_clr -> ovf=0; then pop four in order -> the first four codes.
REQ-044 E0, then no byte for 200_000 cycles (defaults) -> to_err pulse at the terminal count; next byte 1C -> plain make with ext=0.
REQ-045 Byte AA -> sts_valid=1 with sts_code=AA for one cycle, no event; reset=0 asserted while in BRK -> IDLE with FIFO empty.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 keyboard byte constants, decoder states and event record layout
package ps2_pkg;

    localparam logic [7:0] BYTE_EXT      = 8'hE0;
    localparam logic [7:0] BYTE_BRK      = 8'hF0;
    localparam logic [7:0] BYTE_PAUSE    = 8'hE1;
    localparam logic [7:0] STS_BAT_OK    = 8'hAA;
    localparam logic [7:0] STS_ACK       = 8'hFA;
    localparam logic [7:0] STS_ECHO      = 8'hEE;
    localparam logic [7:0] STS_RESEND    = 8'hFE;
    localparam logic [7:0] STS_BAT_ERR   = 8'hFC;
    localparam logic [7:0] STS_OVR_LO    = 8'h00;
    localparam logic [7:0] STS_OVR_HI    = 8'hFF;
    localparam logic [7:0] FAKE_SHIFT_L  = 8'h12;
    localparam logic [7:0] FAKE_SHIFT_R  = 8'h59;

    localparam int EV_W         = 11;
    localparam int EV_CODE_LSB  = 0;
    localparam int EV_REL_BIT   = 8;
    localparam int EV_EXT_BIT   = 9;
    localparam int EV_PAUSE_BIT = 10;
    localparam int FIFO_DEPTH   = 4;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXT   = 2'd1,
        ST_BRK   = 2'd2,
        ST_PAUSE = 2'd3
    } kbd_state_e;

    function automatic logic is_status(input logic [7:0] b);
        return (b == STS_BAT_OK) || (b == STS_ACK) || (b == STS_ECHO) ||
               (b == STS_RESEND) || (b == STS_BAT_ERR) || (b == STS_OVR_LO) ||
               (b == STS_OVR_HI);
    endfunction

    function automatic logic is_fake_shift(input logic [7:0] b);
        return (b == FAKE_SHIFT_L) || (b == FAKE_SHIFT_R);
    endfunction

    function automatic logic [EV_W-1:0] make_event(input logic pause, input logic ext,
                                                  input logic rel, input logic [7:0] code);
        logic [EV_W-1:0] e;
        e = '0;
        e[EV_CODE_LSB +: 8] = code;
        e[EV_REL_BIT]       = rel;
        e[EV_EXT_BIT]       = ext;
        e[EV_PAUSE_BIT]     = pause;
        return e;
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// rtl/ps2_evt_fifo.sv - first-word fall-through event queue, head data reads zero when empty
module ps2_evt_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             in_tvalid_i,
    input  logic [WIDTH-1:0] in_tdata_i,
    output logic             in_tready_o,
    output logic             out_tvalid_o,
    input  logic             out_tready_i,
    output logic [WIDTH-1:0] out_tdata_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             empty, full, do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_FULL);
    assign do_pop  = out_tready_i && !empty;
    // A full queue still accepts a write when the head leaves in the same cycle.
    assign in_tready_o = !full || do_pop;
    assign do_push = in_tvalid_i && in_tready_o;

    assign out_tvalid_o = !empty;
    assign out_tdata_o  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= in_tdata_i;
        end
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// rtl/ps2_kbd_ctrl.sv - PS/2 scan-code set 2 decoder with sequence timeout, status strobe and event queue
module ps2_kbd_ctrl
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TIMEOUT_US = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_rel,
    output logic       ev_pause,
    output logic       sts_valid,
    output logic [7:0] sts_code,
    output logic       to_err,
    output logic       ovf,
    input  logic       ovf_clr
);

    localparam int TO_CYCLES = TIMEOUT_US * (CLK_HZ / 1_000_000);
    localparam int TO_W      = $clog2(TO_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

    kbd_state_e       state_q, state_d;
    logic             ext_flag_q, ext_flag_d;
    logic [2:0]       skip_cnt_q, skip_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             sts_valid_q, sts_valid_d;
    logic [7:0]       sts_code_q, sts_code_d;
    logic             to_err_q, to_err_d;
    logic             ovf_q, ovf_d;
    logic             push;
    logic [EV_W-1:0]  push_ev;
    logic             push_ready;
    logic [EV_W-1:0]  head_ev;

    always_comb begin
        state_d     = state_q;
        ext_flag_d  = ext_flag_q;
        skip_cnt_d  = skip_cnt_q;
        to_cnt_d    = to_cnt_q;
        sts_valid_d = 1'b0;
        sts_code_d  = sts_code_q;
        to_err_d    = 1'b0;
        push        = 1'b0;
        push_ev     = '0;
        if (rx_done) begin
            // A byte arriving on the terminal-count cycle takes priority over the timeout.
            to_cnt_d = '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (rx_data == BYTE_EXT) begin
                        state_d = ST_EXT;
                    end else if (rx_data == BYTE_BRK) begin
                        state_d    = ST_BRK;
                        ext_flag_d = 1'b0;
                    end else if (rx_data == BYTE_PAUSE) begin
                        state_d    = ST_PAUSE;
                        skip_cnt_d = PAUSE_SKIP;
                    end else if (is_status(rx_data)) begin
                        sts_valid_d = 1'b1;
                        sts_code_d  = rx_data;
                    end else begin
                        push    = 1'b1;
                        push_ev = make_event(1'b0, 1'b0, 1'b0, rx_data);
                    end
                end
                ST_EXT: begin
                    if (rx_data == BYTE_BRK) begin
                        state_d    = ST_BRK;
                        ext_flag_d = 1'b1;
                    end else if (rx_data != BYTE_EXT) begin
                        state_d = ST_IDLE;
                        if (!is_fake_shift(rx_data)) begin
                            push    = 1'b1;
                            push_ev = make_event(1'b0, 1'b1, 1'b0, rx_data);
                        end
                    end
                end
                ST_BRK: begin
                    state_d    = ST_IDLE;
                    ext_flag_d = 1'b0;
                    if (!(ext_flag_q && is_fake_shift(rx_data))) begin
                        push    = 1'b1;
                        push_ev = make_event(1'b0, ext_flag_q, 1'b1, rx_data);
                    end
                end
                ST_PAUSE: begin
                    skip_cnt_d = skip_cnt_q - 3'd1;
                    if (skip_cnt_q == 3'd1) begin
                        state_d = ST_IDLE;
                        push    = 1'b1;
                        push_ev = make_event(1'b1, 1'b0, 1'b0, BYTE_PAUSE);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (to_cnt_q == TO_LAST) begin
                state_d    = ST_IDLE;
                ext_flag_d = 1'b0;
                skip_cnt_d = '0;
                to_cnt_d   = '0;
                to_err_d   = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end else begin
            to_cnt_d = '0;
        end
    end

    // Set wins over clear so an overflow in the clearing cycle is never lost.
    assign ovf_d = (push && !push_ready) || (ovf_q && !ovf_clr);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            ext_flag_q  <= 1'b0;
            skip_cnt_q  <= '0;
            to_cnt_q    <= '0;
            sts_valid_q <= 1'b0;
            sts_code_q  <= '0;
            to_err_q    <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ext_flag_q  <= ext_flag_d;
            skip_cnt_q  <= skip_cnt_d;
            to_cnt_q    <= to_cnt_d;
            sts_valid_q <= sts_valid_d;
            sts_code_q  <= sts_code_d;
            to_err_q    <= to_err_d;
            ovf_q       <= ovf_d;
        end
    end

    ps2_evt_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk_i        (clk),
        .resetn_i     (reset),
        .in_tvalid_i  (push),
        .in_tdata_i   (push_ev),
        .in_tready_o  (push_ready),
        .out_tvalid_o (ev_valid),
        .out_tready_i (ev_ready),
        .out_tdata_o  (head_ev)
    );

    assign ev_code   = head_ev[EV_CODE_LSB +: 8];
    assign ev_rel    = head_ev[EV_REL_BIT];
    assign ev_ext    = head_ev[EV_EXT_BIT];
    assign ev_pause  = head_ev[EV_PAUSE_BIT];
    assign sts_valid = sts_valid_q;
    assign sts_code  = sts_code_q;
    assign to_err    = to_err_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb/tb_ps2_kbd_ctrl.sv - key-action level stimulus against a queue model of the event stream
module tb_ps2_kbd_ctrl;

    localparam int T_CYC = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       ev_valid;
    logic       ev_ready = 1'b0;
    logic [7:0] ev_code;
    logic       ev_ext, ev_rel, ev_pause;
    logic       sts_valid;
    logic [7:0] sts_code;
    logic       to_err;
    logic       ovf;
    logic       ovf_clr = 1'b0;

    int checks = 0;
    int failures = 0;
    int rdy_mode = 1;
    bit rand_clr = 1'b0;

    logic [10:0] mq[$];
    logic        m_ovf = 1'b0;

    ps2_kbd_ctrl #(.CLK_HZ(1_000_000), .TIMEOUT_US(T_CYC)) dut (
        .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
        .ev_ext(ev_ext), .ev_rel(ev_rel), .ev_pause(ev_pause),
        .sts_valid(sts_valid), .sts_code(sts_code), .to_err(to_err),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [10:0] ev(input logic p, input logic x, input logic r,
                                       input logic [7:0] c);
        return {p, x, r, c};
    endfunction

    function automatic logic [7:0] rand_code();
        logic [7:0] c;
        do c = 8'($urandom);
        while (c inside {8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE,
                         8'hFC, 8'h00, 8'hFF, 8'h12, 8'h59});
        return c;
    endfunction

    // One clock: drive inputs, advance the model at the edge, then compare outputs.
    task automatic cyc(input logic rxd, input logic [7:0] d, input logic push,
                       input logic [10:0] e, input logic sts, input logic to);
        logic popped, full, drop;
        logic [10:0] head;
        @(negedge clk);
        rx_done  = rxd;
        rx_data  = d;
        ev_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
        if (rand_clr) ovf_clr = ($urandom_range(0, 7) == 0);
        @(posedge clk);
        popped = ev_ready && (mq.size() > 0);
        full   = (mq.size() == 4);
        drop   = 1'b0;
        if (popped) void'(mq.pop_front());
        if (push) begin
            if (full && !popped) drop = 1'b1;
            else mq.push_back(e);
        end
        m_ovf = drop || (m_ovf && !ovf_clr);
        #1;
        rx_done = 1'b0;
        head = (mq.size() > 0) ? mq[0] : 11'h0;
        check("ev_valid", 32'(ev_valid), 32'(mq.size() > 0));
        check("ev_head", {21'h0, ev_pause, ev_ext, ev_rel, ev_code}, {21'h0, head});
        check("sts_valid", 32'(sts_valid), 32'(sts));
        if (sts) check("sts_code", 32'(sts_code), 32'(d));
        check("to_err", 32'(to_err), 32'(to));
        check("ovf", 32'(ovf), 32'(m_ovf));
    endtask

    task automatic byte_ev(input logic [7:0] d, input logic [10:0] e);
        cyc(1'b1, d, 1'b1, e, 1'b0, 1'b0);
    endtask

    task automatic byte_np(input logic [7:0] d);
        cyc(1'b1, d, 1'b0, 11'h0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 11'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        rx_done = 1'b0;
        @(posedge clk);
        #1;
        mq.delete();
        m_ovf = 1'b0;
        check("rst_ev_valid", 32'(ev_valid), 32'd0);
        check("rst_ev_head", {21'h0, ev_pause, ev_ext, ev_rel, ev_code}, 32'd0);
        check("rst_sts_valid", 32'(sts_valid), 32'd0);
        check("rst_to_err", 32'(to_err), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        reset = 1'b1;
    endtask

    task automatic rand_action();
        logic [7:0] c;
        logic [7:0] st [7] = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF};
        c = rand_code();
        case ($urandom_range(0, 7))
            0: byte_ev(c, ev(0, 0, 0, c));
            1: begin byte_np(8'hF0); byte_ev(c, ev(0, 0, 1, c)); end
            2: begin byte_np(8'hE0); byte_ev(c, ev(0, 1, 0, c)); end
            3: begin byte_np(8'hE0); byte_np(8'hF0); byte_ev(c, ev(0, 1, 1, c)); end
            4: begin
                byte_np(8'hE0);
                if ($urandom_range(0, 1) == 1) byte_np(8'hF0);
                byte_np($urandom_range(0, 1) == 1 ? 8'h12 : 8'h59);
            end
            5: begin
                byte_np(8'hE1);
                for (int i = 0; i < 6; i++) byte_np(8'($urandom));
                byte_ev(8'($urandom), ev(1, 0, 0, 8'hE1));
            end
            6: begin
                c = st[$urandom_range(0, 6)];
                cyc(1'b1, c, 1'b0, 11'h0, 1'b1, 1'b0);
            end
            default: begin byte_np(8'hE0); byte_np(8'hE0); byte_ev(c, ev(0, 1, 0, c)); end
        endcase
        idle($urandom_range(0, 3));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("init_ev_valid", 32'(ev_valid), 32'd0);
        check("init_ev_head", {21'h0, ev_pause, ev_ext, ev_rel, ev_code}, 32'd0);
        check("init_sts_valid", 32'(sts_valid), 32'd0);
        check("init_to_err", 32'(to_err), 32'd0);
        check("init_ovf", 32'(ovf), 32'd0);
        reset = 1'b1;

        // Plain make then break, head popped each cycle
        rdy_mode = 1;
        byte_ev(8'h1C, ev(0, 0, 0, 8'h1C));
        byte_np(8'hF0);
        byte_ev(8'h1C, ev(0, 0, 1, 8'h1C));
        idle(2);

        // Extended make/break and fake shift
        byte_np(8'hE0); byte_ev(8'h75, ev(0, 1, 0, 8'h75));
        byte_np(8'hE0); byte_np(8'hF0); byte_ev(8'h75, ev(0, 1, 1, 8'h75));
        byte_np(8'hE0); byte_np(8'h12);
        idle(2);

        // Pause sequence yields exactly one event
        rdy_mode = 0;
        byte_np(8'hE1); byte_np(8'h14); byte_np(8'h77); byte_np(8'hE1);
        byte_np(8'hF0); byte_np(8'h14); byte_np(8'hF0);
        byte_ev(8'h77, ev(1, 0, 0, 8'hE1));
        check("pause_head_code", 32'(ev_code), 32'hE1);
        check("pause_head_flag", 32'(ev_pause), 32'd1);
        rdy_mode = 1;
        idle(2);

        // Overflow: six makes into a stalled queue, clear, then drain
        rdy_mode = 0;
        for (int i = 0; i < 6; i++) byte_ev(8'h20 + 8'(i), ev(0, 0, 0, 8'h20 + 8'(i)));
        check("ovf_set", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(ovf), 32'd0);
        check("ovf_head_first", 32'(ev_code), 32'h20);
        rdy_mode = 1;
        idle(5);

        // Full queue with push and pop in the same cycle
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) byte_ev(8'h30 + 8'(i), ev(0, 0, 0, 8'h30 + 8'(i)));
        rdy_mode = 1;
        byte_ev(8'h3A, ev(0, 0, 0, 8'h3A));
        check("full_pushpop_ovf", 32'(ovf), 32'd0);
        idle(5);

        // Timeout after E0, then a plain make decodes from idle
        byte_np(8'hE0);
        for (int k = 1; k <= T_CYC + 2; k++)
            cyc(1'b0, 8'h00, 1'b0, 11'h0, 1'b0, k == T_CYC);
        byte_ev(8'h1C, ev(0, 0, 0, 8'h1C));
        idle(1);

        // Byte on the terminal-count cycle beats the timeout
        byte_np(8'hE0);
        idle(T_CYC - 1);
        byte_ev(8'h75, ev(0, 1, 0, 8'h75));
        idle(2);

        // Status byte
        cyc(1'b1, 8'hAA, 1'b0, 11'h0, 1'b1, 1'b0);
        idle(1);

        // Reset in the middle of a break sequence
        rdy_mode = 0;
        byte_ev(8'h44, ev(0, 0, 0, 8'h44));
        byte_np(8'hF0);
        do_reset();
        byte_ev(8'h1C, ev(0, 0, 0, 8'h1C));
        rdy_mode = 1;
        idle(2);

        // Randomized key actions with random back-pressure and overflow clears
        rand_clr = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (n % 20 == 0) rdy_mode = $urandom_range(0, 2);
            rand_action();
        end
        rand_clr = 1'b0;
        ovf_clr = 1'b0;
        rdy_mode = 1;
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
